// File: rtl/adder_pipe_nbit.sv
// -----------------------------------------------------------------------------
// adder_pipe_nbit
//   Pipelined ripple-carry add/subtract unit. A BIT_WIDTH-wide operation is cut
//   into STAGES slices of SLICE = BIT_WIDTH/STAGES bits; each pipeline stage adds
//   one slice and registers the carry for the next stage. Operand bits that are
//   not yet consumed travel down the pipe with their transaction (skew), and
//   finished sum slices are carried alongside until the whole word is complete
//   (deskew), so every slice of one transaction leaves the pipe together.
//
//   Stream handshake (both ports): a beat transfers on a cycle where valid and
//   ready are both high. Input side: in_ready = !(out_valid && !out_ready), so
//   the whole pipe freezes only while a finished result waits for the consumer;
//   bubbles never hold anything up. Output side: out_valid/sum/overflow stay
//   stable until out_ready is seen high.
//
// Parameters
//   BIT_WIDTH  operand/sum width (>= 2)
//   STAGES     number of slices; must divide BIT_WIDTH evenly
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; discards everything in flight
//   in_valid   operands/mode presented this cycle
//   in_ready   unit accepts operands this cycle
//   a, b       unsigned operands
//   carry_in   carry into bit 0 (add mode only)
//   sub        0: a + b + carry_in   1: a - b (carry_in ignored)
//   out_valid  result held on sum/overflow
//   out_ready  consumer takes the result this cycle
//   sum        result modulo 2^BIT_WIDTH
//   overflow   add: carry out of MSB; sub: borrow (a < b)
// -----------------------------------------------------------------------------
module adder_pipe_nbit #(
    parameter int BIT_WIDTH = 16,
    parameter int STAGES    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 carry_in,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 overflow
);

    localparam int SLICE = BIT_WIDTH / STAGES;

    logic stall;
    logic adv;

    assign stall    = out_valid && !out_ready;
    assign adv      = !stall;
    assign in_ready = !stall;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            // Operand bits still to be added when a transaction enters stage k.
            localparam int OPW = BIT_WIDTH - k * SLICE;

            logic [OPW-1:0]           a_op;
            logic [OPW-1:0]           b_op;
            logic                     vld_in;
            logic                     sub_in;
            logic                     cy_in;
            logic [SLICE:0]           add_d;
            logic [(k+1)*SLICE-1:0]   s_d;

            logic                     vld_q;
            logic                     sub_q;
            logic                     cy_q;
            logic [(k+1)*SLICE-1:0]   s_q;

            if (k == 0) begin : g_first
                // b is inverted once at the entry; subtract then becomes
                // a + ~b + 1 with the +1 injected as the initial carry.
                assign a_op   = a;
                assign b_op   = sub ? ~b : b;
                assign vld_in = in_valid;
                assign sub_in = sub;
                assign cy_in  = sub | carry_in;
                assign s_d    = add_d[SLICE-1:0];
            end else begin : g_next
                // Skew registers: keep only the operand bits not yet consumed.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        a_op <= '0;
                        b_op <= '0;
                    end else if (adv) begin
                        a_op <= g_stage[k-1].a_op[OPW+SLICE-1:SLICE];
                        b_op <= g_stage[k-1].b_op[OPW+SLICE-1:SLICE];
                    end
                end
                assign vld_in = g_stage[k-1].vld_q;
                assign sub_in = g_stage[k-1].sub_q;
                assign cy_in  = g_stage[k-1].cy_q;
                // New slice lands above the slices finished by earlier stages.
                assign s_d    = {add_d[SLICE-1:0], g_stage[k-1].s_q};
            end

            assign add_d = {1'b0, a_op[SLICE-1:0]}
                         + {1'b0, b_op[SLICE-1:0]}
                         + {{SLICE{1'b0}}, cy_in};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= 1'b0;
                    sub_q <= 1'b0;
                    cy_q  <= 1'b0;
                    s_q   <= '0;
                end else if (adv) begin
                    vld_q <= vld_in;
                    sub_q <= sub_in;
                    cy_q  <= add_d[SLICE];
                    s_q   <= s_d;
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign sum       = g_stage[STAGES-1].s_q;
    // In subtract mode the final carry is the inverse of the borrow.
    assign overflow  = g_stage[STAGES-1].sub_q ^ g_stage[STAGES-1].cy_q;

endmodule

// File: tb/tb_adder_pipe_nbit.sv
module tb_adder_pipe_nbit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT0: 16 bit, 2 stages ----------------
    logic        in_valid0, in_ready0, cin0, sub0, out_valid0, out_ready0, ov0;
    logic [15:0] a0, b0, sum0;

    adder_pipe_nbit #(.BIT_WIDTH(16), .STAGES(2)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a0), .b(b0), .carry_in(cin0), .sub(sub0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .sum(sum0), .overflow(ov0)
    );

    // ---------------- DUT1: 32 bit, 4 stages ----------------
    logic        in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, ov1;
    logic [31:0] a1, b1, sum1;

    adder_pipe_nbit #(.BIT_WIDTH(32), .STAGES(4)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .carry_in(cin1), .sub(sub1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .overflow(ov1)
    );

    // ---------------- scoreboard ----------------
    logic [16:0] exp0_q[$];   // {overflow, sum}
    logic [32:0] exp1_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid0 && out_ready0) begin
            if (exp0_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out0_unexpected: got %0h expected nothing", {ov0, sum0});
            end else begin
                logic [16:0] e;
                e = exp0_q.pop_front();
                chk("out0", {47'd0, ov0, sum0}, {47'd0, e});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid1 && out_ready1) begin
            if (exp1_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out1_unexpected: got %0h expected nothing", {ov1, sum1});
            end else begin
                logic [32:0] e;
                e = exp1_q.pop_front();
                chk("out1", {31'd0, ov1, sum1}, {31'd0, e});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send0(input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input logic ts, input logic [16:0] e);
        in_valid0 = 1'b1;
        a0 = ta; b0 = tb; cin0 = tc; sub0 = ts;
        exp0_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
    endtask

    task automatic send1(input logic [31:0] ta, input logic [31:0] tb,
                         input logic tc, input logic ts, input logic [32:0] e);
        in_valid1 = 1'b1;
        a1 = ta; b1 = tb; cin1 = tc; sub1 = ts;
        exp1_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int n;

        // Test 1: reset with live-looking inputs
        rst = 1'b1;
        in_valid0 = 1'b1; a0 = 16'h1234; b0 = 16'h4321; cin0 = 1'b1; sub0 = 1'b0; out_ready0 = 1'b1;
        in_valid1 = 1'b1; a1 = 32'hDEAD_BEEF; b1 = 32'h1; cin1 = 1'b0; sub1 = 1'b1; out_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid0", {63'd0, out_valid0}, 64'd0);
        chk("rst_sum0", {48'd0, sum0}, 64'd0);
        chk("rst_overflow0", {63'd0, ov0}, 64'd0);
        chk("rst_out_valid1", {63'd0, out_valid1}, 64'd0);
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", {63'd0, in_ready0}, 64'd1);
        @(posedge clk);
        #1;

        // Test 2: carry across slice boundary, latency 2
        send0(16'h00FF, 16'h0001, 1'b0, 1'b0, 17'h0_0100);
        lat = 1;
        while (!out_valid0 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency_s2", lat, 2);
        idle(3);

        // Test 3: add with carry_in, sub with borrow, sub without borrow
        send0(16'hFFFF, 16'h0001, 1'b1, 1'b0, 17'h1_0001);
        send0(16'h0003, 16'h0005, 1'b0, 1'b1, 17'h1_FFFE);
        send0(16'h0005, 16'h0003, 1'b0, 1'b1, 17'h0_0002);
        send0(16'h000A, 16'h000A, 1'b1, 1'b1, 17'h0_0000);   // carry_in ignored in sub
        send0(16'h8000, 16'h8000, 1'b0, 1'b0, 17'h1_0000);
        send0(16'h1234, 16'h0F0F, 1'b1, 1'b0, 17'h0_2144);
        idle(4);

        // Test 4: 8 back-to-back adds, no gaps, first at cycle 2
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send0(16'(i), 16'(i * 256), 1'b0, 1'b0, {1'b0, 16'(i * 257)});
            end
            begin
                n = 0;
                @(negedge clk);
                while (!out_valid0 && n < 20) begin
                    n++;
                    @(negedge clk);
                end
                chk("stream_first", n, 2);
                for (int i = 1; i < 8; i++) begin
                    @(negedge clk);
                    chk("stream_no_gap", {63'd0, out_valid0}, 64'd1);
                end
            end
        join
        idle(4);

        // Test 5: back-pressure with 2 results in flight
        out_ready0 = 1'b0;
        send0(16'h0102, 16'h0304, 1'b0, 1'b0, 17'h0_0406);
        send0(16'hF000, 16'h2000, 1'b0, 1'b0, 17'h1_1000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {63'd0, in_ready0}, 64'd0);
            chk("stall_sum_held", {48'd0, sum0}, 64'h0406);
            chk("stall_valid_held", {63'd0, out_valid0}, 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready0 = 1'b1;
        idle(4);
        chk("stall_drained", exp0_q.size(), 0);

        // Test 6: reset right after acceptance discards the transaction
        send0(16'h00FF, 16'h0001, 1'b0, 1'b0, 17'h0_0100);
        rst = 1'b1;
        exp0_q.delete();
        idle(2);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_flush_out_valid", {63'd0, out_valid0}, 64'd0);
        end
        @(posedge clk);
        #1;

        // Test 6b: 32-bit, 4-stage rerun, latency 4
        send1(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 33'h0_0000_0100);
        lat = 1;
        while (!out_valid1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency_s4", lat, 4);
        idle(2);
        send1(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33'h1_0000_0000);
        send1(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 33'h1_FFFF_FFFF);
        send1(32'h00FF_FF00, 32'h0000_0100, 1'b1, 1'b0, 33'h0_0100_0001);

        // final drain
        n = 0;
        while ((exp0_q.size() != 0 || exp1_q.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("final_drain", exp0_q.size() + exp1_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
